// File: rtl/hw_accel_edge_stats_if.sv
// rtl/hw_accel_edge_stats_if.sv - pixel stream and per-frame statistics bundle for hw_accel_edge_stats
interface hw_accel_edge_stats_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 4
);
  localparam int X_W   = $clog2(IMG_WIDTH);
  localparam int Y_W   = $clog2(IMG_HEIGHT);
  localparam int CNT_W = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);

  logic [DATA_WIDTH-1:0] pixel_in;
  logic                  pixel_in_valid;
  logic                  stats_clear;
  logic [DATA_WIDTH-1:0] pixel_out;
  logic                  pixel_out_valid;
  logic [CNT_W-1:0]      edge_count;
  logic [X_W-1:0]        bbox_x_min;
  logic [X_W-1:0]        bbox_x_max;
  logic [Y_W-1:0]        bbox_y_min;
  logic [Y_W-1:0]        bbox_y_max;
  logic                  bbox_valid;
  logic                  frame_done;
  logic                  stats_ready;
  logic [15:0]           frame_count;

  modport master (
    output pixel_in, pixel_in_valid, stats_clear,
    input  pixel_out, pixel_out_valid, edge_count,
    input  bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_valid,
    input  frame_done, stats_ready, frame_count
  );

  modport slave (
    input  pixel_in, pixel_in_valid, stats_clear,
    output pixel_out, pixel_out_valid, edge_count,
    output bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_valid,
    output frame_done, stats_ready, frame_count
  );
endinterface

// File: rtl/hw_accel_edge_stats.sv
// rtl/hw_accel_edge_stats.sv - Sobel edge-stream pass-through with per-frame edge count, bounding box and frame counter
// Bounding box logic is built only when HW_ACCEL_EDGE_STATS_BBOX_EN is defined; otherwise bbox outputs read 0.
module hw_accel_edge_stats #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 10,
  parameter int IMG_HEIGHT = 4
) (
  input logic                  clk,
  input logic                  rstn,
  hw_accel_edge_stats_if.slave bus
);
  localparam int X_W   = $clog2(IMG_WIDTH);
  localparam int Y_W   = $clog2(IMG_HEIGHT);
  localparam int CNT_W = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

  logic [X_W-1:0]   x_cnt;
  logic [Y_W-1:0]   y_cnt;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] acc_cnt_nxt;
  logic             is_edge;
  logic             is_last;

  always_comb begin
    is_edge     = bus.pixel_in_valid && (bus.pixel_in != '0);
    is_last     = bus.pixel_in_valid && (x_cnt == X_LAST) && (y_cnt == Y_LAST);
    acc_cnt_nxt = acc_cnt + CNT_W'(is_edge);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      x_cnt               <= '0;
      y_cnt               <= '0;
      acc_cnt             <= '0;
      bus.pixel_out       <= '0;
      bus.pixel_out_valid <= 1'b0;
      bus.edge_count      <= '0;
      bus.frame_done      <= 1'b0;
      bus.stats_ready     <= 1'b0;
      bus.frame_count     <= '0;
    end else begin
      bus.pixel_out       <= bus.pixel_in;
      bus.pixel_out_valid <= bus.pixel_in_valid;
      bus.frame_done      <= is_last;

      // Setting covers both the load edge and the pulse cycle, so a clear
      // arriving while frame_done is high cannot drop the fresh result.
      if (is_last || bus.frame_done)
        bus.stats_ready <= 1'b1;
      else if (bus.stats_clear)
        bus.stats_ready <= 1'b0;

      if (bus.pixel_in_valid) begin
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end

      if (is_last) begin
        acc_cnt         <= '0;
        bus.edge_count  <= acc_cnt_nxt;
        bus.frame_count <= bus.frame_count + 16'd1;
      end else begin
        acc_cnt <= acc_cnt_nxt;
      end
    end
  end

`ifdef HW_ACCEL_EDGE_STATS_BBOX_EN
  logic [X_W-1:0] acc_xmin, acc_xmax, xmin_nxt, xmax_nxt;
  logic [Y_W-1:0] acc_ymin, acc_ymax, ymin_nxt, ymax_nxt;
  logic           acc_any, any_nxt;

  always_comb begin
    xmin_nxt = acc_xmin;
    xmax_nxt = acc_xmax;
    ymin_nxt = acc_ymin;
    ymax_nxt = acc_ymax;
    any_nxt  = acc_any;
    if (is_edge) begin
      if (x_cnt < acc_xmin) xmin_nxt = x_cnt;
      if (x_cnt > acc_xmax) xmax_nxt = x_cnt;
      if (y_cnt < acc_ymin) ymin_nxt = y_cnt;
      if (y_cnt > acc_ymax) ymax_nxt = y_cnt;
      any_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_xmin       <= X_LAST;
      acc_xmax       <= '0;
      acc_ymin       <= Y_LAST;
      acc_ymax       <= '0;
      acc_any        <= 1'b0;
      bus.bbox_x_min <= '0;
      bus.bbox_x_max <= '0;
      bus.bbox_y_min <= '0;
      bus.bbox_y_max <= '0;
      bus.bbox_valid <= 1'b0;
    end else if (is_last) begin
      acc_xmin       <= X_LAST;
      acc_xmax       <= '0;
      acc_ymin       <= Y_LAST;
      acc_ymax       <= '0;
      acc_any        <= 1'b0;
      // An edge-free frame reports an all-zero box rather than the init sentinels.
      bus.bbox_x_min <= any_nxt ? xmin_nxt : '0;
      bus.bbox_x_max <= any_nxt ? xmax_nxt : '0;
      bus.bbox_y_min <= any_nxt ? ymin_nxt : '0;
      bus.bbox_y_max <= any_nxt ? ymax_nxt : '0;
      bus.bbox_valid <= any_nxt;
    end else begin
      acc_xmin <= xmin_nxt;
      acc_xmax <= xmax_nxt;
      acc_ymin <= ymin_nxt;
      acc_ymax <= ymax_nxt;
      acc_any  <= any_nxt;
    end
  end
`else
  assign bus.bbox_x_min = '0;
  assign bus.bbox_x_max = '0;
  assign bus.bbox_y_min = '0;
  assign bus.bbox_y_max = '0;
  assign bus.bbox_valid = 1'b0;
`endif

endmodule
